// File: rtl/uart_rx_fifo_param.sv
// Oversampling UART receiver (configurable frame format) feeding a first-word-fall-through receive FIFO.
// Define UART_RX_MAJORITY_EN to take every bit as a 2-of-3 vote around mid-bit.
//
// state      | meaning
// IDLE       | line idle, waiting for a falling edge
// START      | qualifying the start bit at mid-bit
// DATA       | shifting in DATA_BITS data bits, LSB first
// PARITY     | sampling the parity bit
// STOP       | sampling STOP_BITS stop bits, then writing the FIFO
// BREAK_WAIT | line held low after an all-zero framing error

module uart_rx_fifo_param #(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int BAUD_RATE       = 19200,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY_MODE     = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_serial_in,
    input  logic                       fifo_rd_en,
    input  logic                       clr_overrun,
    output logic [DATA_BITS-1:0]       fifo_data_out,
    output logic [1:0]                 fifo_err_out,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [FIFO_DEPTH_BITS:0]   fifo_count,
    output logic                       rx_done,
    output logic                       overrun_flag
);

    localparam int DIV     = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE + 1);
    localparam int DEPTH   = 2 ** FIFO_DEPTH_BITS;
    localparam int ENTRY_W = DATA_BITS + 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_TICK = OVERSAMPLE / 2 + 1;
`else
    localparam int SAMPLE_TICK = OVERSAMPLE / 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
    } state_t;

    logic                     sync1_q, line_q;
    logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
    logic                     tick;
    logic [OS_W-1:0]          tick_cnt_q, tick_cnt_d, tick_nxt, tick_target;
    logic                     sample, bit_val, ferr_now;
    state_t                   state_q, state_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic                     perr_q, perr_d, ferr_q, ferr_d;
    logic                     rx_done_q, rx_done_d;
    logic [ENTRY_W-1:0]       wr_word_q, wr_word_d;
    logic [FIFO_DEPTH_BITS:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]       mem_q [DEPTH];
    logic [ENTRY_W-1:0]       mem_d [DEPTH];
    logic [ENTRY_W-1:0]       head;
    logic                     overrun_q, overrun_d;
    logic                     wr_en, rd_en, full, empty;

    assign tick        = (div_cnt_q == DIV_W'(DIV - 1));
    assign tick_nxt    = tick_cnt_q + OS_W'(1);
    assign tick_target = (state_q == S_START) ? OS_W'(SAMPLE_TICK) : OS_W'(OVERSAMPLE);
    assign sample      = tick && (tick_nxt == tick_target);

`ifdef UART_RX_MAJORITY_EN
    // Line values at the two previous ticks; the current line is the third vote.
    logic [1:0] hist_q, hist_d;
    assign hist_d  = tick ? {hist_q[0], line_q} : hist_q;
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & line_q) | (hist_q[0] & line_q);

    always_ff @(posedge clk) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= hist_d;
    end
`else
    assign bit_val = line_q;
`endif

    always_comb begin
        if (state_q == S_IDLE && !line_q) div_cnt_d = '0;
        else if (tick)                    div_cnt_d = '0;
        else                              div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? tick_nxt : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        rx_done_d  = 1'b0;
        wr_word_d  = wr_word_q;
        ferr_now   = ferr_q | !bit_val;
        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
                if (!line_q) state_d = S_START;
            end
            S_START: if (sample) begin
                tick_cnt_d = '0;
                state_d    = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: if (sample) begin
                tick_cnt_d = '0;
                shift_d    = {bit_val, shift_q[DATA_BITS-1:1]};
                bit_cnt_d  = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (sample) begin
                tick_cnt_d = '0;
                perr_d     = ((^shift_q) ^ bit_val) != (PARITY_MODE == 2);
                state_d    = S_STOP;
            end
            S_STOP: if (sample) begin
                tick_cnt_d = '0;
                ferr_d     = ferr_now;
                bit_cnt_d  = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                    rx_done_d = 1'b1;
                    wr_word_d = {ferr_now, perr_q, shift_q};
                    // An all-zero frame with the line still low is a break: swallow it until release.
                    if (ferr_now && shift_q == '0 && !line_q) state_d = S_BREAK_WAIT;
                    else                                      state_d = S_IDLE;
                end
            end
            S_BREAK_WAIT: if (line_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_DEPTH_BITS] != rd_ptr_q[FIFO_DEPTH_BITS]) &&
                   (wr_ptr_q[FIFO_DEPTH_BITS-1:0] == rd_ptr_q[FIFO_DEPTH_BITS-1:0]);
    assign wr_en = rx_done_q & (!full | fifo_rd_en);
    assign rd_en = fifo_rd_en & !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[FIFO_DEPTH_BITS-1:0]] = wr_word_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        // A new overrun takes priority over a clear in the same cycle.
        if (rx_done_q && full && !fifo_rd_en) overrun_d = 1'b1;
        else if (clr_overrun)                 overrun_d = 1'b0;
        else                                  overrun_d = overrun_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            line_q     <= 1'b1;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_done_q  <= 1'b0;
            wr_word_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q    <= rx_serial_in;
            line_q     <= sync1_q;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            rx_done_q  <= rx_done_d;
            wr_word_q  <= wr_word_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overrun_q  <= overrun_d;
            mem_q      <= mem_d;
        end
    end

    assign head          = mem_q[rd_ptr_q[FIFO_DEPTH_BITS-1:0]];
    assign fifo_data_out = head[DATA_BITS-1:0];
    assign fifo_err_out  = head[ENTRY_W-1:DATA_BITS];
    assign fifo_empty    = empty;
    assign fifo_full     = full;
    assign fifo_count    = wr_ptr_q - rd_ptr_q;
    assign rx_done       = rx_done_q;
    assign overrun_flag  = overrun_q;

endmodule
